// File: rtl/vedic_pkg.sv
// Shared definitions for the sequential Vedic multiplier: controller states and digit width.
package vedic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DIGIT_W = 4;

endpackage

// File: rtl/vedic_mul_4x4.sv
// Combinational 4x4 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier built from four 2x2 blocks.
module vedic_mul_4x4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);

    function automatic logic [3:0] vm2(input logic [1:0] x, input logic [1:0] y);
        logic s1, c1, s2, c2;
        s1  = (x[1] & y[0]) ^ (x[0] & y[1]);
        c1  = (x[1] & y[0]) & (x[0] & y[1]);
        s2  = (x[1] & y[1]) ^ c1;
        c2  = (x[1] & y[1]) & c1;
        vm2 = {c2, s2, s1, x[0] & y[0]};
    endfunction

    logic [3:0] q0, q1, q2, q3;
    logic [4:0] mid;

    always_comb begin
        q0  = vm2(a_i[1:0], b_i[1:0]);
        q1  = vm2(a_i[3:2], b_i[1:0]);
        q2  = vm2(a_i[1:0], b_i[3:2]);
        q3  = vm2(a_i[3:2], b_i[3:2]);
        // Cross terms share weight 2^2; their sum needs one extra bit.
        mid = {1'b0, q1} + {1'b0, q2};
        p_o = {4'b0000, q0} + {1'b0, mid, 2'b00} + {q3, 4'b0000};
    end

endmodule

// File: rtl/vedic_seq_mul.sv
// Multi-cycle unsigned multiplier: one 4x4 Vedic core is time-shared over every digit pair,
// with the partial products shift-accumulated into a 2*WIDTH-bit register.
module vedic_seq_mul
    import vedic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int DIGITS = WIDTH / DIGIT_W;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int ACC_W  = 2 * WIDTH;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     i_q, i_d, j_q, j_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [ACC_W-1:0]     acc_q, acc_d, prod_q, prod_d;
    logic [DIGIT_W-1:0]   a_dig, b_dig;
    logic [2*DIGIT_W-1:0] pp;
    logic [ACC_W-1:0]     pp_sh, acc_sum;

    vedic_mul_4x4 u_core (
        .a_i (a_dig),
        .b_i (b_dig),
        .p_o (pp)
    );

    always_comb begin
        a_dig   = DIGIT_W'(a_q >> (DIGIT_W * i_q));
        b_dig   = DIGIT_W'(b_q >> (DIGIT_W * j_q));
        // Shift is evaluated at full accumulator width so no partial-product bits are lost.
        pp_sh   = ACC_W'(pp) << (DIGIT_W * (i_q + j_q));
        acc_sum = acc_q + pp_sh;
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_sum;
                if (j_q == LAST) begin
                    j_d = '0;
                    if (i_q == LAST) begin
                        i_d     = '0;
                        prod_d  = acc_sum;
                        state_d = DONE;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = prod_q;

endmodule
